// File: rtl/stretch_pkg.sv
// rtl/stretch_pkg.sv - shared types, constants and divider state enum for the contrast-stretch stage
package stretch_pkg;

  typedef logic [7:0]  pix_t;
  typedef logic [15:0] gain_t;
  typedef logic [23:0] prod_t;

  // Gain is unsigned fixed point with FRAC_W fractional bits; 256 is unity.
  localparam int    FRAC_W   = 8;
  localparam gain_t GAIN_ONE = 16'd256;
  // 255 << FRAC_W: dividing by the measured range yields the stretch gain.
  localparam gain_t GAIN_NUM = 16'd65280;
  localparam int    PIPE_LAT = 3;
  localparam int    DIV_CYC  = 16;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    LOAD
  } div_state_t;

endpackage

// File: rtl/stretch_div.sv
// rtl/stretch_div.sv - restoring divider computing GAIN_NUM / divisor, one quotient bit per cycle
module stretch_div
  import stretch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  logic  abort,
  input  logic  skip,
  input  pix_t  divisor,
  output logic  busy,
  output logic  done,
  output gain_t quotient
);

  div_state_t state;
  logic [3:0] cnt;
  gain_t      num_sh;
  gain_t      q_sh;
  pix_t       rem;
  pix_t       dvs;
  logic [8:0] rem_sh;
  logic       fits;
  pix_t       rem_next;

  // One restoring step: bring down the next numerator bit and try to subtract.
  always_comb begin
    rem_sh   = {rem, num_sh[15]};
    fits     = (rem_sh >= {1'b0, dvs});
    rem_next = fits ? 8'(rem_sh - {1'b0, dvs}) : rem_sh[7:0];
  end

  // Divider FSM: a start always restarts (even mid-division); done is high during LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      num_sh   <= '0;
      q_sh     <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= GAIN_ONE;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        dvs    <= divisor;
        num_sh <= GAIN_NUM;
        q_sh   <= '0;
        rem    <= '0;
        cnt    <= '0;
        busy   <= 1'b1;
        if (skip) begin
          // Too narrow a range: go straight to LOAD with unity gain.
          quotient <= GAIN_ONE;
          state    <= LOAD;
          done     <= 1'b1;
        end else begin
          state <= DIV;
        end
      end else if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
          end
          DIV: begin
            num_sh <= {num_sh[14:0], 1'b0};
            q_sh   <= {q_sh[14:0], fits};
            rem    <= rem_next;
            cnt    <= cnt + 4'd1;
            if (cnt == 4'(DIV_CYC - 1)) begin
              quotient <= {q_sh[14:0], fits};
              state    <= LOAD;
              done     <= 1'b1;
            end
          end
          LOAD: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/gray_minmax_stretch.sv
// rtl/gray_minmax_stretch.sv - per-frame min/max contrast stretch of 8-bit gray video (optional STRETCH_STATUS_EN status ports)
module gray_minmax_stretch
  import stretch_pkg::*;
#(
  parameter int MIN_RANGE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_img_vsync,
  input  logic        per_img_hsync,
  input  logic        per_img_valid,
  input  logic [7:0]  per_img_gray,
  output logic        post_img_vsync,
  output logic        post_img_hsync,
  output logic        post_img_valid,
  output logic [7:0]  post_img_gray
`ifdef STRETCH_STATUS_EN
  ,
  output logic [7:0]  stat_min,
  output logic [7:0]  stat_max,
  output logic [15:0] stat_gain,
  output logic        coef_update
`endif
);

  localparam pix_t MIN_RANGE_P = pix_t'(MIN_RANGE);

  logic  vsync_d;
  logic  boundary;
  pix_t  acc_min;
  pix_t  acc_max;
  pix_t  range_now;
  logic  seen;
  pix_t  pend_min;
  pix_t  pend_range;
  pix_t  act_min;
  gain_t act_gain;

  logic  div_start;
  logic  div_abort;
  logic  div_skip;
  logic  div_busy;
  logic  div_done;
  gain_t div_quot;
  logic  load_en;

  logic [PIPE_LAT-1:0] vs_dl;
  logic [PIPE_LAT-1:0] hs_dl;
  logic [PIPE_LAT-1:0] v_dl;
  pix_t  s1_diff;
  gain_t s1_gain;
  prod_t s2_prod;
  logic [16:0] s3_y;
  pix_t  s3_gray;

  assign boundary  = per_img_vsync & ~vsync_d;
  assign range_now = acc_max - acc_min;
  assign div_start = boundary & seen;
  assign div_skip  = (range_now < MIN_RANGE_P);
  // An empty frame ending mid-division cancels the in-flight update: coefficients stay put.
  assign div_abort = boundary & ~seen & div_busy;
  // A boundary landing on the LOAD cycle supersedes that load.
  assign load_en   = div_done & ~boundary;

  // Registered copy of vsync for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_d <= 1'b0;
    else        vsync_d <= per_img_vsync;
  end

  // Frame statistics; a boundary snapshots them and restarts the accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min    <= 8'd255;
      acc_max    <= 8'd0;
      seen       <= 1'b0;
      pend_min   <= '0;
      pend_range <= '0;
    end else if (boundary) begin
      if (seen) begin
        pend_min   <= acc_min;
        pend_range <= range_now;
      end
      acc_min <= 8'd255;
      acc_max <= 8'd0;
      seen    <= 1'b0;
    end else if (per_img_valid) begin
      if (per_img_gray < acc_min) acc_min <= per_img_gray;
      if (per_img_gray > acc_max) acc_max <= per_img_gray;
      seen <= 1'b1;
    end
  end

  stretch_div u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (div_abort),
    .skip     (div_skip),
    .divisor  (range_now),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  // Active coefficient pair, written together so a pixel never sees a mixed set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_min  <= '0;
      act_gain <= GAIN_ONE;
    end else if (load_en) begin
      act_gain <= div_quot;
      act_min  <= (pend_range < MIN_RANGE_P) ? '0 : pend_min;
    end
  end

  // Sync delay lines, fixed latency regardless of valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_dl <= '0;
      hs_dl <= '0;
      v_dl  <= '0;
    end else begin
      vs_dl <= {vs_dl[PIPE_LAT-2:0], per_img_vsync};
      hs_dl <= {hs_dl[PIPE_LAT-2:0], per_img_hsync};
      v_dl  <= {v_dl[PIPE_LAT-2:0], per_img_valid};
    end
  end

  // Rounding and saturation of the product back to 8 bits.
  always_comb begin
    s3_y = 17'((25'(s2_prod) + 25'(1 << (FRAC_W - 1))) >> FRAC_W);
  end

  // Pixel datapath: offset removal, gain multiply, round/saturate. Gain travels with the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_diff <= '0;
      s1_gain <= '0;
      s2_prod <= '0;
      s3_gray <= '0;
    end else begin
      s1_diff <= (per_img_gray > act_min) ? (per_img_gray - act_min) : '0;
      s1_gain <= act_gain;
      s2_prod <= prod_t'(s1_diff) * prod_t'(s1_gain);
      if (!v_dl[1])          s3_gray <= '0;
      else if (|s3_y[16:8])  s3_gray <= 8'd255;
      else                   s3_gray <= s3_y[7:0];
    end
  end

  assign post_img_vsync = vs_dl[PIPE_LAT-1];
  assign post_img_hsync = hs_dl[PIPE_LAT-1];
  assign post_img_valid = v_dl[PIPE_LAT-1];
  assign post_img_gray  = s3_gray;

`ifdef STRETCH_STATUS_EN
  // Status mirror: last captured frame range, active gain and a pulse per coefficient load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_min    <= '0;
      stat_max    <= '0;
      stat_gain   <= '0;
      coef_update <= 1'b0;
    end else begin
      coef_update <= load_en;
      if (boundary && seen) begin
        stat_min <= acc_min;
        stat_max <= acc_max;
      end
      if (load_en) stat_gain <= div_quot;
    end
  end
`endif

endmodule

// File: tb/tb_gray_minmax_stretch.sv
// tb/tb_gray_minmax_stretch.sv - directed table-driven bench for gray_minmax_stretch
module tb_gray_minmax_stretch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0;
  logic       hs = 1'b0;
  logic       v = 1'b0;
  logic [7:0] g = 8'd0;
  logic       post_vs;
  logic       post_hs;
  logic       post_v;
  logic [7:0] post_g;
`ifdef STRETCH_STATUS_EN
  logic [7:0]  stat_min;
  logic [7:0]  stat_max;
  logic [15:0] stat_gain;
  logic        coef_update;
`endif

  gray_minmax_stretch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .per_img_vsync  (vs),
    .per_img_hsync  (hs),
    .per_img_valid  (v),
    .per_img_gray   (g),
    .post_img_vsync (post_vs),
    .post_img_hsync (post_hs),
    .post_img_valid (post_v),
    .post_img_gray  (post_g)
`ifdef STRETCH_STATUS_EN
    ,
    .stat_min       (stat_min),
    .stat_max       (stat_max),
    .stat_gain      (stat_gain),
    .coef_update    (coef_update)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Expected output for the pixel currently driven, carried 3 cycles by the bench.
  logic [7:0]  e_in = 8'd0;
  logic [10:0] d1 = '0;
  logic [10:0] d2 = '0;
  logic [10:0] d3 = '0;
  bit          mon_en = 1'b0;

  always @(posedge clk) begin
    d3 = d2;
    d2 = d1;
    d1 = {vs, hs, v, e_in};
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("sync_align", int'({post_vs, post_hs, post_v}), int'(d3[10:8]));
      check("gray", int'(post_g), d3[8] ? int'(d3[7:0]) : 0);
    end
  end

  int          gain_chg = 0;
  int          upd_cnt = 0;
  logic [15:0] last_gain = '0;
  always @(negedge clk) begin
    if (dut.act_gain !== last_gain) gain_chg++;
    last_gain = dut.act_gain;
`ifdef STRETCH_STATUS_EN
    if (coef_update) upd_cnt++;
`endif
  end

  task automatic drive(input bit vs_i, input bit hs_i, input bit v_i,
                       input logic [7:0] g_i, input logic [7:0] e_i);
    @(negedge clk);
    vs = vs_i; hs = hs_i; v = v_i; g = g_i; e_in = e_i;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic blank();
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    idle(30);
  endtask

  typedef struct {
    bit         sync;
    logic [7:0] gray;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(input bit s, input int gg, input int ee);
    vec_t r;
    r.sync = s;
    r.gray = 8'(gg);
    r.exp  = 8'(ee);
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    // Frame A: 50..200 under identity
    tbl.push_back(mk(0, 50, 50));  tbl.push_back(mk(0, 200, 200));
    tbl.push_back(mk(0, 100, 100)); tbl.push_back(mk(1, 0, 0));
    // Frame B: min 50, gain 435
    tbl.push_back(mk(0, 50, 0));   tbl.push_back(mk(0, 125, 127));
    tbl.push_back(mk(0, 200, 255)); tbl.push_back(mk(1, 0, 0));
    // Frame C: still min 50 gain 435; clamp and saturate
    tbl.push_back(mk(0, 30, 0));   tbl.push_back(mk(0, 230, 255));
    tbl.push_back(mk(1, 0, 0));
    // Frame D: flat 100 under min 30 gain 326
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 100, 89));
    tbl.push_back(mk(1, 0, 0));
    // Frame E: identity after flat frame
    tbl.push_back(mk(0, 100, 100)); tbl.push_back(mk(0, 7, 7));
    tbl.push_back(mk(1, 0, 0));
    // Empty frame: coefficients (min 7, gain 701) must survive
    tbl.push_back(mk(1, 0, 0));
    // Frame F
    tbl.push_back(mk(0, 50, 118)); tbl.push_back(mk(0, 7, 0));
    tbl.push_back(mk(0, 100, 255)); tbl.push_back(mk(0, 200, 255));
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vsync", int'(post_vs), 0);
    check("rst_hsync", int'(post_hs), 0);
    check("rst_valid", int'(post_v), 0);
    check("rst_gray", int'(post_g), 0);
    check("rst_gain", int'(dut.act_gain), 256);
    check("rst_min", int'(dut.act_min), 0);
    rst_n = 1'b1;
    idle(3);
    mon_en = 1'b1;

    // Frame 1: ramp under identity, exact 3-cycle latency with hsync alignment
    for (int i = 0; i < 256; i++) drive(1'b0, bit'((i >> 3) & 1), 1'b1, 8'(i), 8'(i));
    idle(3);
    blank();

    // Table-driven frames
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sync) blank();
      else drive(1'b0, 1'b0, 1'b1, tbl[i].gray, tbl[i].exp);
    end
    idle(3);

    // Double boundary: second one lands mid-division; only its capture may load
    gain_chg = 0;
    upd_cnt  = 0;
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b0, 1'b0, 1'b1, 8'd60, 8'd145);
    drive(1'b0, 1'b0, 1'b1, 8'd140, 8'd255);
    idle(2);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    idle(30);
    check("restart_gain_changes", gain_chg, 1);
    check("restart_gain", int'(dut.act_gain), 816);
    check("restart_min", int'(dut.act_min), 60);
`ifdef STRETCH_STATUS_EN
    check("restart_updates", upd_cnt, 1);
    check("stat_min", int'(stat_min), 60);
    check("stat_max", int'(stat_max), 140);
    check("stat_gain", int'(stat_gain), 816);
`endif
    // Frame G under min 60 gain 816
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd128);
    drive(1'b0, 1'b0, 1'b1, 8'd140, 8'd255);
    drive(1'b0, 1'b0, 1'b1, 8'd60, 8'd0);

    // Reset mid-frame with valid output in flight
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, 8'd100, 8'd128);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("midframe_rst_valid", int'(post_v), 0);
    check("midframe_rst_hsync", int'(post_hs), 0);
    check("midframe_rst_gray", int'(post_g), 0);
    idle(4);
    rst_n = 1'b1;
    idle(3);
    mon_en = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 8'd100, 8'd100);
    drive(1'b0, 1'b0, 1'b1, 8'd200, 8'd200);
    idle(3);

    // Reset mid-division: no coefficients may arrive afterwards
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    idle(3);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("middiv_rst_vsync", int'(post_vs), 0);
    check("middiv_rst_gray", int'(post_g), 0);
    check("middiv_rst_gain", int'(dut.act_gain), 256);
    idle(4);
    rst_n = 1'b1;
    idle(3);
    mon_en = 1'b1;
    idle(25);
    drive(1'b0, 1'b0, 1'b1, 8'd50, 8'd50);
    drive(1'b0, 1'b0, 1'b1, 8'd250, 8'd250);
    idle(5);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gray_minmax_stretch.md
Name: gray_minmax_stretch

Overview:
Automatic contrast-stretch stage for the 8-bit gray video stream. It sits directly upstream of the curve-contrast LUT stage and consumes the stream produced by the bmp-to-video source. During frame N it measures the min and max gray over valid pixels. It remaps frame N+1 linearly so that [min,max] maps to [0,255]. Per-frame gain comes from a small sequential divider that runs during vertical blanking.

Parameters:
MIN_RANGE, 16, if (max-min) < MIN_RANGE, the frame's coefficients are identity (prevents noise blow-up on flat images)
FRAC_W, 8, fractional bits of the gain (fixed, documented for package consistency)

Ports:
clk  input  1  pixel clock
rst_n  input  1  asynchronous reset, active low
per_img_vsync  input  1  frame sync; a rising edge marks a frame boundary
per_img_hsync  input  1  line sync; delayed only
per_img_valid  input  1  pixel valid
per_img_gray  input  8  input gray pixel
post_img_vsync  output  1  per_img_vsync delayed 3 cycles
post_img_hsync  output  1  per_img_hsync delayed 3 cycles
post_img_valid  output  1  per_img_valid delayed 3 cycles
post_img_gray  output  8  stretched pixel, aligned with post_img_valid

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset state:
  - All outputs 0.
  - Delay lines cleared.
  - Active coefficients identity: act_min=0, act_gain=256.
  - Accumulators: acc_min=255, acc_max=0, seen=0.
  - Divider FSM IDLE.
- Statistics: on every cycle with per_img_valid=1:
  - acc_min <= min(acc_min, gray); acc_max <= max(acc_max, gray); seen <= 1.
- Frame boundary: a rising edge of per_img_vsync, detected against a registered copy.
  - If seen=1, capture pend_min=acc_min and pend_range=acc_max-acc_min, then start the divider.
  - Reset the accumulators to 255/0 and seen=0.
  - If seen=0 (frame had no valid pixels), keep the current coefficients and do not start the divider.
- Divider FSM states: IDLE -> DIV (16 cycles) -> LOAD -> IDLE.
  - Unsigned restoring division: quotient = 65280 / pend_range (65280 = 255<<8).
  - 16-bit quotient, one quotient bit per cycle.
  - If pend_range < MIN_RANGE, skip DIV: LOAD sets act_min=0, act_gain=256.
  - LOAD writes act_min and act_gain in the same cycle (atomic; the pair is never mixed).
  - A new boundary while in DIV/LOAD aborts and restarts with the new values.
  - Total boundary-to-coefficients latency: 18 cycles, well inside blanking.
- Pixel pipeline, latency 3 cycles, fixed regardless of valid:
  - S1: diff = (gray > act_min) ? gray-act_min : 0 (8 bit).
  - S2: prod = diff * act_gain (24 bit unsigned).
  - S3: y = (prod + 128) >> 8; post_img_gray = (y > 255) ? 255 : y[7:0].
  - post_img_gray is forced to 0 when the S3 valid is 0.
- Coefficients update only via LOAD. A LOAD mid-frame is not possible in legal video; if it occurs, later pixels use the new set.
- First frame after reset is identity.

Optional Feature:
STRETCH_STATUS_EN
- Defined: adds output ports stat_min[7:0], stat_max[7:0], stat_gain[15:0] and coef_update (1-cycle pulse on LOAD).
  - Values come from the last captured frame and the active gain.
  - Reset value 0.
- Undefined: these ports and their registers do not exist; functional behaviour is unchanged.

Decomposition:
- Package stretch_pkg: pix_t (logic[7:0]), gain_t (logic[15:0]), prod_t (logic[23:0]), constants GAIN_ONE=256, GAIN_NUM=65280, PIPE_LAT=3, DIV_CYC=16, and the FSM state enum (IDLE, DIV, LOAD).
- Sub-module stretch_div: restoring divider with start, busy, done and abort.
  - Top module keeps statistics, boundary detect, coefficient registers and the pixel pipeline.

Test Plan:
- Reset then frame 1 with a ramp 0..255 -> frame 1 output equals input (identity), delayed exactly 3 cycles, with syncs aligned.
- Frame 1 pixels in 50..200, then frame 2 inputs 50/125/200 -> act_gain=435; outputs 0/127/255.
- After the 50..200 frame, frame 3 inputs 30 and 230 -> outputs 0 (clamp) and 255 (saturate).
- Flat frame of all 100 (range 0 < MIN_RANGE) -> next frame identity (100 -> 100). A frame with no valid pixels -> coefficients unchanged.
- Two vsync rising edges 5 cycles apart (second during DIV) -> divider restarts; the final coefficients reflect the second capture only, and there is no LOAD pulse from the first.
- Assert rst_n low mid-frame and mid-DIV -> outputs go to 0 immediately; after release the next frame is identity.
